rf_ldst_seq: RTL
================

# rf_ldst_seq

Command sequencer that sits directly upstream of the register-file load/store engine. Accepts whole-tensor load/store commands of up to 2^LEN_W−1 lines from the NPU master through a small command FIFO. Splits each command into chunks of at most CHUNK_MAX lines, drives the engine's start/address/line-count inputs, and waits for its done pulse between chunks. Reports per-command completion back to the master.

## Interface
- SDRAM_ADDR_W, 25, SDRAM byte-address width
- RF_ADDR_W, 9, register-file line-address width
- LEN_W, 16, command line-count width
- CHUNK_MAX, 255, max lines per engine transaction (1..255)
- LINE_STRIDE, 176, SDRAM bytes advanced per RF line
- CMD_DEPTH, 4, command FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_store  in  1  1 = store (RF→SDRAM), 0 = load
- cmd_sdram_addr  in  SDRAM_ADDR_W  first SDRAM byte address
- cmd_rf_addr  in  RF_ADDR_W  first RF line
- cmd_lines  in  LEN_W  total lines
- ldst_sdram_addr  out  SDRAM_ADDR_W  chunk SDRAM address
- ldst_rf_addr  out  RF_ADDR_W  chunk RF line
- ldst_line_num  out  8  chunk line count
- load_start  out  1  one-cycle chunk load start
- store_start  out  1  one-cycle chunk store start
- ldst_done  in  1  one-cycle chunk completion from engine
- busy  out  1  command in flight or FIFO non-empty
- cmd_done  out  1  one-cycle pulse per completed command
- perf_busy_cycles  out  32  see Configuration
- perf_chunks  out  32  see Configuration

## Operation
- Command is accepted on the cycle where cmd_valid && cmd_ready; cmd_ready = !fifo_full (no bypass).
- States: IDLE, ISSUE, WAIT.
- IDLE: if FIFO is non-empty, pop into working regs (op, saddr, raddr, remaining) and go to ISSUE.
- ISSUE: if remaining == 0, pulse cmd_done and go to IDLE. Otherwise set chunk = min(remaining, CHUNK_MAX) and drive ldst_* with the chunk. Assert load_start or store_start (per op) for exactly one cycle, then go to WAIT.
- WAIT: ldst_* are held stable. On ldst_done:
  - saddr += chunk*LINE_STRIDE, truncated to SDRAM_ADDR_W (wraps).
  - raddr += chunk modulo 2^RF_ADDR_W (wraps).
  - remaining −= chunk.
  - Go to ISSUE.
- Zero-length command: no start is issued; cmd_done pulses. Commands complete in acceptance order.
- ldst_done outside WAIT is ignored.
- Reset mid-operation: all state cleared, FIFO emptied, no start or cmd_done emitted; engine reset is the integrator's responsibility.
- Reset values: cmd_ready 1, all ldst_* 0, load_start 0, store_start 0, busy 0, cmd_done 0, perf counters 0.

## Timing
- Command accepted at edge N → popped at N+1 → start asserted in the cycle after N+1 (first start ≥2 cycles after acceptance).
- ldst_done seen at edge M → next start asserted in cycle M+1 (one-cycle inter-chunk gap).
- Final ldst_done at edge M → cmd_done pulses in cycle M+1; next queued command's start follows ≥2 cycles later.
- Push while popping from a full FIFO: push is refused (cmd_ready low that cycle).
- Chunk math uses LEN_W+SDRAM_ADDR_W-bit intermediates; the multiply by LINE_STRIDE is constant.

## Configuration
- LDST_SEQ_PERF_EN defined:
  - perf_busy_cycles counts cycles with busy high.
  - perf_chunks counts asserted start pulses.
  - Both saturate at 2^32−1 and clear only on reset.
- Undefined: both ports are tied to 0 and no counter logic is instantiated.

## Structure
- Package npu_ldst_pkg holds:
  - ldst_cmd_t: packed struct of store, sdram_addr, rf_addr, lines.
  - seq_state_t: IDLE/ISSUE/WAIT enum.
  - Default constants CHUNK_MAX and LINE_STRIDE.
- Sub-module ldst_cmd_fifo: synchronous FIFO of ldst_cmd_t, CMD_DEPTH entries, full/empty flags, async active-low reset.

## Test plan
- Load, sdram 0x100, rf 10, 3 lines → one load_start with ldst_line_num=3, rf 10, sdram 0x100; after ldst_done, cmd_done pulses once.
- Store, 600 lines → chunks of 255/255/90; sdram 0x0, 0xAF50, 0x15EA0; rf 0, 255, 510→wraps to 510 mod 512; three store_start, one cmd_done.
- cmd_lines=0 → no start pulses, cmd_done one cycle after the pop.
- Push 5 commands back-to-back with ldst_done withheld → cmd_ready drops after 4 accepted. Release done pulses → executed in order.
- ldst_done injected in IDLE → no state change. rst_n low during WAIT → outputs reach reset values immediately; no cmd_done afterward.
- With LDST_SEQ_PERF_EN, the 600-line store → perf_chunks=3.

Source files
------------

// File: rtl/npu_ldst_pkg.sv
// Shared types and default constants for the register-file load/store sequencer.
package npu_ldst_pkg;

    localparam int unsigned SDRAM_ADDR_W = 25;
    localparam int unsigned RF_ADDR_W    = 9;
    localparam int unsigned LEN_W        = 16;
    localparam int unsigned CHUNK_MAX    = 255;
    localparam int unsigned LINE_STRIDE  = 176;
    localparam int unsigned CMD_DEPTH    = 4;

    typedef struct packed {
        logic                    store;
        logic [SDRAM_ADDR_W-1:0] sdram_addr;
        logic [RF_ADDR_W-1:0]    rf_addr;
        logic [LEN_W-1:0]        lines;
    } ldst_cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } seq_state_t;

endpackage

// File: rtl/rf_ldst_seq_if.sv
// Command, engine and status signals of rf_ldst_seq.
// master = NPU/engine side, slave = sequencer.
interface rf_ldst_seq_if #(
    parameter int unsigned SDRAM_ADDR_W = npu_ldst_pkg::SDRAM_ADDR_W,
    parameter int unsigned RF_ADDR_W    = npu_ldst_pkg::RF_ADDR_W,
    parameter int unsigned LEN_W        = npu_ldst_pkg::LEN_W
) ();

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_store;
    logic [SDRAM_ADDR_W-1:0] cmd_sdram_addr;
    logic [RF_ADDR_W-1:0]    cmd_rf_addr;
    logic [LEN_W-1:0]        cmd_lines;
    logic [SDRAM_ADDR_W-1:0] ldst_sdram_addr;
    logic [RF_ADDR_W-1:0]    ldst_rf_addr;
    logic [7:0]              ldst_line_num;
    logic                    load_start;
    logic                    store_start;
    logic                    ldst_done;
    logic                    busy;
    logic                    cmd_done;
    logic [31:0]             perf_busy_cycles;
    logic [31:0]             perf_chunks;

    modport master (
        output cmd_valid, cmd_store, cmd_sdram_addr, cmd_rf_addr, cmd_lines, ldst_done,
        input  cmd_ready, ldst_sdram_addr, ldst_rf_addr, ldst_line_num, load_start,
               store_start, busy, cmd_done, perf_busy_cycles, perf_chunks
    );

    modport slave (
        input  cmd_valid, cmd_store, cmd_sdram_addr, cmd_rf_addr, cmd_lines, ldst_done,
        output cmd_ready, ldst_sdram_addr, ldst_rf_addr, ldst_line_num, load_start,
               store_start, busy, cmd_done, perf_busy_cycles, perf_chunks
    );

endinterface

// File: rtl/ldst_cmd_fifo.sv
// Small synchronous command FIFO with full/empty flags; read data is the head entry.
module ldst_cmd_fifo #(
    parameter int unsigned CMD_DEPTH = npu_ldst_pkg::CMD_DEPTH,
    parameter type         entry_t   = npu_ldst_pkg::ldst_cmd_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = $clog2(CMD_DEPTH);

    entry_t           mem_q [CMD_DEPTH];
    logic [PTR_W:0]   wr_q;
    logic [PTR_W:0]   rd_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign empty   = (wr_q == rd_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_q <= rd_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/rf_ldst_seq.sv
// Splits queued whole-tensor load/store commands into engine-sized chunks.
// Define LDST_SEQ_PERF_EN to build the busy-cycle and chunk performance counters.
module rf_ldst_seq #(
    parameter int unsigned SDRAM_ADDR_W = npu_ldst_pkg::SDRAM_ADDR_W,
    parameter int unsigned RF_ADDR_W    = npu_ldst_pkg::RF_ADDR_W,
    parameter int unsigned LEN_W        = npu_ldst_pkg::LEN_W,
    parameter int unsigned CHUNK_MAX    = npu_ldst_pkg::CHUNK_MAX,
    parameter int unsigned LINE_STRIDE  = npu_ldst_pkg::LINE_STRIDE,
    parameter int unsigned CMD_DEPTH    = npu_ldst_pkg::CMD_DEPTH
) (
    input logic          clk,
    input logic          rst_n,
    rf_ldst_seq_if.slave bus
);

    import npu_ldst_pkg::*;

    localparam int unsigned MATH_W = LEN_W + SDRAM_ADDR_W;

    typedef struct packed {
        logic                    store;
        logic [SDRAM_ADDR_W-1:0] sdram_addr;
        logic [RF_ADDR_W-1:0]    rf_addr;
        logic [LEN_W-1:0]        lines;
    } cmd_t;

    cmd_t fifo_wdata;
    cmd_t fifo_rdata;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;

    seq_state_t              state_q, state_d;
    logic                    op_q, op_d;
    logic [SDRAM_ADDR_W-1:0] saddr_q, saddr_d;
    logic [RF_ADDR_W-1:0]    raddr_q, raddr_d;
    logic [LEN_W-1:0]        rem_q, rem_d;

    logic [7:0]              chunk;
    logic [MATH_W-1:0]       saddr_sum;
    logic                    load_start;
    logic                    store_start;
    logic                    cmd_done;
    logic                    busy;

    assign fifo_wdata.store      = bus.cmd_store;
    assign fifo_wdata.sdram_addr = bus.cmd_sdram_addr;
    assign fifo_wdata.rf_addr    = bus.cmd_rf_addr;
    assign fifo_wdata.lines      = bus.cmd_lines;
    assign fifo_push             = bus.cmd_valid && !fifo_full;

    ldst_cmd_fifo #(
        .CMD_DEPTH (CMD_DEPTH),
        .entry_t   (cmd_t)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Chunk is derived from the remaining count, so it stays stable for the whole WAIT.
    always_comb begin
        if (rem_q > LEN_W'(CHUNK_MAX)) chunk = 8'(CHUNK_MAX);
        else                           chunk = rem_q[7:0];
    end

    assign saddr_sum = MATH_W'(saddr_q) + MATH_W'(chunk) * MATH_W'(LINE_STRIDE);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        saddr_d     = saddr_q;
        raddr_d     = raddr_q;
        rem_d       = rem_q;
        fifo_pop    = 1'b0;
        load_start  = 1'b0;
        store_start = 1'b0;
        cmd_done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_rdata.store;
                    saddr_d  = fifo_rdata.sdram_addr;
                    raddr_d  = fifo_rdata.rf_addr;
                    rem_d    = fifo_rdata.lines;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (rem_q == '0) begin
                    cmd_done = 1'b1;
                    state_d  = StIdle;
                end else begin
                    load_start  = !op_q;
                    store_start = op_q;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (bus.ldst_done) begin
                    saddr_d = saddr_sum[SDRAM_ADDR_W-1:0];
                    raddr_d = raddr_q + RF_ADDR_W'(chunk);
                    rem_d   = rem_q - LEN_W'(chunk);
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= 1'b0;
            saddr_q <= '0;
            raddr_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            saddr_q <= saddr_d;
            raddr_q <= raddr_d;
            rem_q   <= rem_d;
        end
    end

    assign busy                = (state_q != StIdle) || !fifo_empty;
    assign bus.cmd_ready       = !fifo_full;
    assign bus.ldst_sdram_addr = saddr_q;
    assign bus.ldst_rf_addr    = raddr_q;
    assign bus.ldst_line_num   = chunk;
    assign bus.load_start      = load_start;
    assign bus.store_start     = store_start;
    assign bus.cmd_done        = cmd_done;
    assign bus.busy            = busy;

`ifdef LDST_SEQ_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_chunks_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q   <= '0;
            perf_chunks_q <= '0;
        end else begin
            if (busy && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
            if ((load_start || store_start) && (perf_chunks_q != '1)) begin
                perf_chunks_q <= perf_chunks_q + 32'd1;
            end
        end
    end

    assign bus.perf_busy_cycles = perf_busy_q;
    assign bus.perf_chunks      = perf_chunks_q;
`else
    assign bus.perf_busy_cycles = '0;
    assign bus.perf_chunks      = '0;
`endif

endmodule
